status_register: RTL and testbench

STATUS_REGISTER -- requirements
Module: status_register

---
 rtl/status_register.sv | 107 ++++++++++
 tb/tb_status_register.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/status_register.sv
// status_register: CPSR/SPSR condition-flag register for a pipelined core.
// Holds the live {N,Z,C,V} flags (cpsr), a one-deep exception shadow (spsr),
// and a two-state NORM/EXC tracker. It also produces registered ack/err pulses
// for save/restore requests and a saturating count of committed flag updates.
// Optional feature macro: STATUS_BYPASS_EN. When it is defined, status_out
// forwards status_in combinationally while an update is committing.
module status_register (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] status_in,
   input  logic       s_bit,
   input  logic       stall,
   input  logic       flush,
   input  logic       save_req,
   input  logic       restore_req,
   output logic [3:0] status_out,
   output logic       in_exc,
   output logic       ack,
   output logic       err,
   output logic [7:0] upd_cnt
);

   typedef enum logic {
      NORM = 1'b0,
      EXC  = 1'b1
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] cpsr;
   logic [3:0] spsr;

   logic       commit;
   logic       restore_ok;
   logic       save_ok;
   logic       restore_bad;
   logic       save_bad;
   logic [3:0] post_update;

   // Decode this cycle's request outcomes. A restore request takes priority
   // over a simultaneous save, so the save is neither accepted nor flagged.
   always_comb begin
      commit      = s_bit & ~stall & ~flush;
      restore_ok  = restore_req & ~stall & (state == EXC);
      restore_bad = restore_req & ~stall & (state == NORM);
      save_ok     = save_req & ~restore_req & ~stall & (state == NORM);
      save_bad    = save_req & ~restore_req & ~stall & (state == EXC);
      post_update = commit ? status_in : cpsr;
   end

   // FSM next state: NORM->EXC on an accepted save, EXC->NORM on an accepted restore.
   always_comb begin
      state_next = state;
      case (state)
         NORM: if (save_ok) state_next = EXC;
         EXC:  if (restore_ok) state_next = NORM;
         default: state_next = NORM;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= NORM;
      else        state <= state_next;
   end

   // Flag registers: a restore overrides any same-cycle update; a save captures the post-update flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpsr <= 4'b0000;
         spsr <= 4'b0000;
      end else begin
         if (restore_ok) cpsr <= spsr;
         else            cpsr <= post_update;
         if (save_ok)    spsr <= post_update;
      end
   end

   // One-cycle ack/err pulses; a stalled cycle always clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack <= 1'b0;
         err <= 1'b0;
      end else begin
         ack <= save_ok | restore_ok;
         err <= save_bad | restore_bad;
      end
   end

   // Saturating count of updates that actually landed in cpsr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_cnt <= 8'd0;
      end else if (commit && !restore_ok && (upd_cnt != 8'hFF)) begin
         upd_cnt <= upd_cnt + 8'd1;
      end
   end

   assign in_exc = (state == EXC);

`ifdef STATUS_BYPASS_EN
   assign status_out = (commit && !restore_ok) ? status_in : cpsr;
`else
   assign status_out = cpsr;
`endif

endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed self-checking bench for status_register.
// Steps are written as a linear sequence; every expected value is hand-computed.
module tb_status_register;

   logic       clk;
   logic       rst_n;
   logic [3:0] status_in;
   logic       s_bit;
   logic       stall;
   logic       flush;
   logic       save_req;
   logic       restore_req;
   logic [3:0] status_out;
   logic       in_exc;
   logic       ack;
   logic       err;
   logic [7:0] upd_cnt;

   int passed;
   int total;

   status_register dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .status_in   (status_in),
      .s_bit       (s_bit),
      .stall       (stall),
      .flush       (flush),
      .save_req    (save_req),
      .restore_req (restore_req),
      .status_out  (status_out),
      .in_exc      (in_exc),
      .ack         (ack),
      .err         (err),
      .upd_cnt     (upd_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) begin
         passed++;
      end else begin
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs from the falling edge, let the rising edge
   // take them, then return all request inputs to idle 1 ns after the edge.
   task automatic apply_stimulus(input logic [3:0] st, input logic s, input logic stl,
                                 input logic fl, input logic sv, input logic rs);
      @(negedge clk);
      status_in   = st;
      s_bit       = s;
      stall       = stl;
      flush       = fl;
      save_req    = sv;
      restore_req = rs;
      @(posedge clk);
      #1;
      status_in   = 4'b0000;
      s_bit       = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      save_req    = 1'b0;
      restore_req = 1'b0;
   endtask

   initial begin
      passed      = 0;
      total       = 0;
      rst_n       = 1'b0;
      status_in   = 4'b0000;
      s_bit       = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      save_req    = 1'b0;
      restore_req = 1'b0;

      // Reset state
      #2;
      check_output("reset_status_out", {4'b0, status_out}, 8'h00);
      check_output("reset_in_exc", {7'b0, in_exc}, 8'h00);
      check_output("reset_ack", {7'b0, ack}, 8'h00);
      check_output("reset_err", {7'b0, err}, 8'h00);
      check_output("reset_upd_cnt", upd_cnt, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Update: status_in=0100 with s_bit, bypass visibility checked before the edge
      @(negedge clk);
      status_in = 4'b0100;
      s_bit     = 1'b1;
      #1;
`ifdef STATUS_BYPASS_EN
      check_output("bypass_same_cycle", {4'b0, status_out}, 8'h04);
`else
      check_output("no_bypass_same_cycle", {4'b0, status_out}, 8'h00);
`endif
      @(posedge clk);
      #1;
      status_in = 4'b0000;
      s_bit     = 1'b0;
      check_output("update_status_out", {4'b0, status_out}, 8'h04);
      check_output("update_cnt", upd_cnt, 8'h01);

      // Flush suppresses the update
      apply_stimulus(4'b1001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_output("flush_status_out", {4'b0, status_out}, 8'h04);
      check_output("flush_cnt", upd_cnt, 8'h01);
      check_output("flush_ack", {7'b0, ack}, 8'h00);
      check_output("flush_err", {7'b0, err}, 8'h00);

      // Stall freezes everything
      apply_stimulus(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_output("stall_status_out", {4'b0, status_out}, 8'h04);
      check_output("stall_cnt", upd_cnt, 8'h01);
      check_output("stall_ack", {7'b0, ack}, 8'h00);
      check_output("stall_err", {7'b0, err}, 8'h00);

      // Save/restore round trip
      apply_stimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("rt_update", {4'b0, status_out}, 8'h02);
      check_output("rt_update_cnt", upd_cnt, 8'h02);
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("rt_save_ack", {7'b0, ack}, 8'h01);
      check_output("rt_save_in_exc", {7'b0, in_exc}, 8'h01);
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("rt_ack_pulse_end", {7'b0, ack}, 8'h00);
      check_output("rt_idle_in_exc", {7'b0, in_exc}, 8'h01);
      apply_stimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("rt_exc_update", {4'b0, status_out}, 8'h0F);
      check_output("rt_exc_update_cnt", upd_cnt, 8'h03);
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("rt_restore_status", {4'b0, status_out}, 8'h02);
      check_output("rt_restore_in_exc", {7'b0, in_exc}, 8'h00);
      check_output("rt_restore_ack", {7'b0, ack}, 8'h01);

      // Illegal restore in NORM
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("bad_restore_err", {7'b0, err}, 8'h01);
      check_output("bad_restore_ack", {7'b0, ack}, 8'h00);
      check_output("bad_restore_in_exc", {7'b0, in_exc}, 8'h00);
      check_output("bad_restore_status", {4'b0, status_out}, 8'h02);
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("err_pulse_end", {7'b0, err}, 8'h00);

      // Save with same-cycle update: shadow captures 0101
      apply_stimulus(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("save_upd_ack", {7'b0, ack}, 8'h01);
      check_output("save_upd_in_exc", {7'b0, in_exc}, 8'h01);
      check_output("save_upd_status", {4'b0, status_out}, 8'h05);
      check_output("save_upd_cnt", upd_cnt, 8'h04);

      // Illegal save in EXC: err, legal update still commits, shadow untouched
      apply_stimulus(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("bad_save_err", {7'b0, err}, 8'h01);
      check_output("bad_save_ack", {7'b0, ack}, 8'h00);
      check_output("bad_save_in_exc", {7'b0, in_exc}, 8'h01);
      check_output("bad_save_status", {4'b0, status_out}, 8'h09);
      check_output("bad_save_cnt", upd_cnt, 8'h05);

      // Save+restore together in EXC with an update: restore wins, update not counted
      apply_stimulus(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check_output("both_status", {4'b0, status_out}, 8'h05);
      check_output("both_in_exc", {7'b0, in_exc}, 8'h00);
      check_output("both_ack", {7'b0, ack}, 8'h01);
      check_output("both_err", {7'b0, err}, 8'h00);
      check_output("both_cnt", upd_cnt, 8'h05);

      // Saturation: 300 committed updates from count 5
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_output("sat_cnt", upd_cnt, 8'hFF);
      check_output("sat_status", {4'b0, status_out}, 8'h0B);
      apply_stimulus(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("sat_hold_cnt", upd_cnt, 8'hFF);
      check_output("sat_hold_status", {4'b0, status_out}, 8'h0C);

      // Reset mid-operation: reach EXC with upd_cnt=7
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         apply_stimulus(4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_output("pre_rst_in_exc", {7'b0, in_exc}, 8'h01);
      check_output("pre_rst_cnt", upd_cnt, 8'h07);
      check_output("pre_rst_status", {4'b0, status_out}, 8'h07);
      apply_stimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check_output("stall_restore_in_exc", {7'b0, in_exc}, 8'h01);
      check_output("stall_restore_ack", {7'b0, ack}, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_status", {4'b0, status_out}, 8'h00);
      check_output("midrst_in_exc", {7'b0, in_exc}, 8'h00);
      check_output("midrst_cnt", upd_cnt, 8'h00);
      check_output("midrst_ack", {7'b0, ack}, 8'h00);
      check_output("midrst_err", {7'b0, err}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("post_rst_restore_err", {7'b0, err}, 8'h01);
      check_output("post_rst_restore_in_exc", {7'b0, in_exc}, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
